sd_spi_cmd_engine: RTL and testbench
====================================

Name: sd_spi_cmd_engine

Overview:
- Parametrised SD-card command/response engine in SPI mode, with its own mode-0 shifter and clock divider.
- Accepts one command (index + argument), computes CRC7 and sends the 48-bit frame.
- Polls for R1, captures 0-4 extra response bytes, and optionally receives one data block, streamed out bytewise.
- Sits between the SD controller FSM (init/read sequencing) and the card pins; replaces hand-built 48-bit frames and fixed-length buffers.

Parameters:
- DIV_SLOW, 125, sclk half-period in clk cycles when fast=0 (init, <=400 kHz).
- DIV_FAST, 2, sclk half-period in clk cycles when fast=1.
- NCR_MAX, 16, max 0xFF bytes polled for the R1 start.
- TOKEN_MAX, 4096, max bytes polled for the data start token.
- BLOCK_LEN, 512, data bytes per block.
- DUMMY_BYTES, 10, 0xFF bytes clocked with ss_n high on a dummy request.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  request strobe
- cmd_ready  out  1  engine idle, request accepted when cmd_valid&&cmd_ready
- dummy  in  1  request is power-up dummy clocks, command fields ignored
- fast  in  1  select DIV_FAST, else DIV_SLOW; sampled at accept
- cmd_idx  in  6  command index
- cmd_arg  in  32  command argument
- resp_len  in  3  extra response bytes after R1, 0..4 (5..7 treated as 4)
- data_rd  in  1  expect a data block after the response
- done  out  1  one-cycle pulse, transaction finished
- err  out  2  0 ok, 1 R1 timeout, 2 token timeout, 3 data error token; valid with done, held until next accept
- r1  out  8  R1 byte, held until next accept
- resp  out  32  extra bytes, first received at MSB, right-aligned for resp_len<4
- dout  out  8  data byte
- dout_valid  out  1  one-cycle pulse per data byte; no backpressure
- spi_ss_n, spi_sclk, spi_mosi  out  1  card pins
- spi_miso  in  1  card pin

Behaviour:
- Reset (async assert, sync release): ss_n=1, sclk=0, mosi=1, cmd_ready=1, done=0, dout_valid=0, err=0, r1=0, resp=0, dout=0.
- Reset mid-transfer: pins return to idle immediately, no done pulse.
- SPI mode 0, MSB first: sclk idles low; mosi changes on the falling edge (first bit set up before the first rising edge); miso sampled on the rising edge. Each sclk phase lasts exactly DIV clk cycles.
- Byte engine: shifts one byte out and one in; mosi=1 whenever no data is being transmitted.
- Frame bytes: 0x40|idx, arg[31:24..7:0], {crc7,1}. crc7 uses polynomial x^7+x^3+1, initial value 0, over the first 5 bytes.
- States:
  - IDLE: cmd_ready=1. On accept, go to DUMMY if dummy=1, else SEND. Inputs latched; cmd_ready drops the next cycle.
  - DUMMY: ss_n=1, DUMMY_BYTES x 0xFF, then DONE with err=0.
  - SEND: ss_n=0, 6 frame bytes.
  - NCR: clock 0xFF bytes until a byte has MSB=0. That byte is latched to r1; go to RESP, or to DATA-wait if resp_len=0. After NCR_MAX bytes with no response: err=1, go to TAIL.
  - RESP: receive resp_len bytes into resp.
  - TOKEN (only if data_rd, entered after RESP/NCR): poll bytes.
    - 0xFE: go to DATA.
    - Any other non-0xFF byte: err=3, go to TAIL.
    - TOKEN_MAX bytes of 0xFF: err=2, go to TAIL.
  - DATA: BLOCK_LEN bytes; dout_valid pulses once per byte, in the cycle after its 8th rising edge.
  - CRC16: 2 bytes received and discarded.
  - TAIL: one 0xFF byte with ss_n=0, then ss_n=1.
  - DONE: done=1 for one cycle, then IDLE.
- If data_rd=0, RESP/NCR success goes directly to TAIL.
- cmd_valid while busy is ignored (not queued).
- An R1 with error bits set is not an engine error: err=0 and r1 is reported as received; data_rd is still honoured.

Test Plan:
- cmd_idx=0, arg=0, fast=0, miso returns FF,FF,01 -> mosi bytes 40 00 00 00 00 95; sclk half-period 125 clk; r1=0x01, err=0, one done pulse, ss_n high after TAIL.
- cmd_idx=8, arg=0x000001AA, resp_len=4, miso returns 01 00 00 01 AA -> mosi ends with 0x87; resp=0x000001AA, err=0.
- miso held 1, any command -> exactly NCR_MAX polled bytes after SEND, then err=1 and done; no dout_valid.
- cmd_idx=17, data_rd=1, fast=1, miso returns R1 00, FF x3, FE, bytes 0..255 twice, 2 CRC bytes -> 512 dout_valid pulses with dout = i mod 256; err=0; sclk half-period 2 clk.
- Same read with token 0x05 -> err=3, zero dout_valid, done after TAIL.
- dummy=1 -> 80 sclk rising edges with ss_n=1 and mosi=1, done, err=0.
- Assert rst mid-DATA -> ss_n=1 and sclk=0 in the same cycle; cmd_ready=1 after release; no done.

Source files
------------

// File: rtl/sd_spi_cmd_engine.sv
// sd_spi_cmd_engine
//   SD-card command/response engine for SPI mode. Takes one command (index +
//   argument), appends CRC7, shifts out the 48-bit frame, polls for R1, grabs
//   0..4 extra response bytes and optionally receives one data block that is
//   streamed out a byte at a time. Includes its own mode-0 shifter and sclk
//   divider.
//
// Ports
//   clk, rst                  system clock, asynchronous active-low reset
//   cmd_valid / cmd_ready     request handshake (accepted when both high)
//   dummy                     request is DUMMY_BYTES of 0xFF with ss_n high
//   fast                      sclk half-period DIV_FAST instead of DIV_SLOW
//   cmd_idx, cmd_arg          command fields
//   resp_len                  extra response bytes after R1 (5..7 act as 4)
//   data_rd                   expect a data block after the response
//   done                      one-cycle completion pulse
//   err                       0 ok, 1 R1 timeout, 2 token timeout, 3 error token
//   r1, resp                  received response, held until next accept
//   dout, dout_valid          data block bytes, one pulse per byte
//   spi_ss_n, spi_sclk, spi_mosi, spi_miso   card pins
//
// DIV_FAST and DIV_SLOW must be >= 2: the next byte is handed to the shifter
// during the high phase of the previous byte's last bit.
module sd_spi_cmd_engine #(
    parameter int DIV_SLOW    = 125,
    parameter int DIV_FAST    = 2,
    parameter int NCR_MAX     = 16,
    parameter int TOKEN_MAX   = 4096,
    parameter int BLOCK_LEN   = 512,
    parameter int DUMMY_BYTES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        dummy,
    input  logic        fast,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    input  logic [2:0]  resp_len,
    input  logic        data_rd,
    output logic        done,
    output logic [1:0]  err,
    output logic [7:0]  r1,
    output logic [31:0] resp,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        spi_ss_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int DW      = $clog2(DIV_MAX + 1);
    localparam int CNT_A   = (TOKEN_MAX > BLOCK_LEN) ? TOKEN_MAX : BLOCK_LEN;
    localparam int CNT_B   = (NCR_MAX > DUMMY_BYTES) ? NCR_MAX : DUMMY_BYTES;
    localparam int CNT_MAX = (CNT_A > CNT_B) ? CNT_A : CNT_B;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_DUMMY, S_SEND, S_NCR, S_RESP, S_TOKEN,
        S_DATA, S_CRC, S_TAIL, S_FIN, S_DONE
    } state_t;

    // CRC7 (x^7 + x^3 + 1, init 0) over the first five frame bytes
    function automatic logic [6:0] crc7(input logic [39:0] msg);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = msg[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // control state
    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [39:0]     frame_reg;
    logic [2:0]      rlen_reg;
    logic            data_rd_reg, fast_reg;
    logic            ss_n_reg, cmd_ready_reg, done_reg;
    logic [1:0]      err_reg;
    logic [7:0]      r1_reg;
    logic [31:0]     resp_reg;
    logic            start_reg;
    logic [7:0]      tx_byte_reg;

    // byte shifter state
    logic            eng_busy_reg, sclk_reg, mosi_reg;
    logic [DW-1:0]   div_cnt_reg;
    logic [2:0]      bit_cnt_reg;
    logic [7:0]      tx_sh_reg;
    logic [6:0]      rx_sh_reg;
    logic            rx_valid_reg;
    logic [7:0]      rx_byte_reg;
    logic            pend_reg;
    logic [7:0]      pend_byte_reg;
    logic [7:0]      dout_reg;
    logic            dout_valid_reg;

    logic [DW-1:0]   div_last;
    logic [7:0]      next_byte;
    logic            in_data;

    assign div_last  = fast_reg ? DW'(DIV_FAST - 1) : DW'(DIV_SLOW - 1);
    assign next_byte = start_reg ? tx_byte_reg : pend_byte_reg;
    assign in_data   = (state_reg == S_DATA);

    // Mode-0 shifter. A start while busy is parked in pend_reg and picked up
    // at the final falling edge so consecutive bytes run without a gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_busy_reg   <= 1'b0;
            sclk_reg       <= 1'b0;
            mosi_reg       <= 1'b1;
            div_cnt_reg    <= '0;
            bit_cnt_reg    <= '0;
            tx_sh_reg      <= 8'hFF;
            rx_sh_reg      <= '0;
            rx_valid_reg   <= 1'b0;
            rx_byte_reg    <= '0;
            pend_reg       <= 1'b0;
            pend_byte_reg  <= 8'hFF;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
        end else begin
            rx_valid_reg   <= 1'b0;
            dout_valid_reg <= 1'b0;
            if (!eng_busy_reg) begin
                if (start_reg) begin
                    eng_busy_reg <= 1'b1;
                    tx_sh_reg    <= tx_byte_reg;
                    mosi_reg     <= tx_byte_reg[7];
                    div_cnt_reg  <= '0;
                    bit_cnt_reg  <= '0;
                end
            end else begin
                if (start_reg) begin
                    pend_reg      <= 1'b1;
                    pend_byte_reg <= tx_byte_reg;
                end
                if (div_cnt_reg == div_last) begin
                    div_cnt_reg <= '0;
                    if (!sclk_reg) begin
                        sclk_reg  <= 1'b1;
                        rx_sh_reg <= {rx_sh_reg[5:0], spi_miso};
                        if (bit_cnt_reg == 3'd7) begin
                            rx_valid_reg <= 1'b1;
                            rx_byte_reg  <= {rx_sh_reg, spi_miso};
                            if (in_data) begin
                                dout_reg       <= {rx_sh_reg, spi_miso};
                                dout_valid_reg <= 1'b1;
                            end
                        end
                    end else begin
                        sclk_reg    <= 1'b0;
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg != 3'd7) begin
                            mosi_reg  <= tx_sh_reg[6];
                            tx_sh_reg <= {tx_sh_reg[6:0], 1'b1};
                        end else if (start_reg || pend_reg) begin
                            tx_sh_reg <= next_byte;
                            mosi_reg  <= next_byte[7];
                            pend_reg  <= 1'b0;
                        end else begin
                            eng_busy_reg <= 1'b0;
                            mosi_reg     <= 1'b1;
                        end
                    end
                end else begin
                    div_cnt_reg <= div_cnt_reg + DW'(1);
                end
            end
        end
    end

    // Transaction sequencer. Every decision is taken on rx_valid_reg, i.e.
    // early in the high phase of a byte's last bit, and the following byte is
    // requested immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            frame_reg     <= '0;
            rlen_reg      <= '0;
            data_rd_reg   <= 1'b0;
            fast_reg      <= 1'b0;
            ss_n_reg      <= 1'b1;
            cmd_ready_reg <= 1'b1;
            done_reg      <= 1'b0;
            err_reg       <= '0;
            r1_reg        <= '0;
            resp_reg      <= '0;
            start_reg     <= 1'b0;
            tx_byte_reg   <= 8'hFF;
        end else begin
            start_reg <= 1'b0;
            case (state_reg)
                S_IDLE: if (cmd_valid) begin
                    cmd_ready_reg <= 1'b0;
                    fast_reg      <= fast;
                    rlen_reg      <= (resp_len > 3'd4) ? 3'd4 : resp_len;
                    data_rd_reg   <= data_rd;
                    err_reg       <= '0;
                    r1_reg        <= '0;
                    resp_reg      <= '0;
                    cnt_reg       <= '0;
                    start_reg     <= 1'b1;
                    if (dummy) begin
                        tx_byte_reg <= 8'hFF;
                        state_reg   <= S_DUMMY;
                    end else begin
                        ss_n_reg    <= 1'b0;
                        tx_byte_reg <= {2'b01, cmd_idx};
                        frame_reg   <= {cmd_arg, crc7({2'b01, cmd_idx, cmd_arg}), 1'b1};
                        state_reg   <= S_SEND;
                    end
                end
                S_DUMMY: if (rx_valid_reg) begin
                    if (cnt_reg == CW'(DUMMY_BYTES - 1)) begin
                        state_reg <= S_FIN;
                    end else begin
                        cnt_reg   <= cnt_reg + CW'(1);
                        start_reg <= 1'b1;
                    end
                end
                S_SEND: if (rx_valid_reg) begin
                    start_reg <= 1'b1;
                    if (cnt_reg == CW'(5)) begin
                        cnt_reg     <= '0;
                        tx_byte_reg <= 8'hFF;
                        state_reg   <= S_NCR;
                    end else begin
                        cnt_reg     <= cnt_reg + CW'(1);
                        tx_byte_reg <= frame_reg[39:32];
                        frame_reg   <= {frame_reg[31:0], 8'hFF};
                    end
                end
                S_NCR: if (rx_valid_reg) begin
                    start_reg <= 1'b1;
                    if (!rx_byte_reg[7]) begin
                        r1_reg  <= rx_byte_reg;
                        cnt_reg <= '0;
                        if (rlen_reg != 3'd0) state_reg <= S_RESP;
                        else                  state_reg <= data_rd_reg ? S_TOKEN : S_TAIL;
                    end else if (cnt_reg == CW'(NCR_MAX - 1)) begin
                        err_reg   <= 2'd1;
                        state_reg <= S_TAIL;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                S_RESP: if (rx_valid_reg) begin
                    start_reg <= 1'b1;
                    resp_reg  <= {resp_reg[23:0], rx_byte_reg};
                    if (cnt_reg == CW'(rlen_reg - 3'd1)) begin
                        cnt_reg   <= '0;
                        state_reg <= data_rd_reg ? S_TOKEN : S_TAIL;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                S_TOKEN: if (rx_valid_reg) begin
                    start_reg <= 1'b1;
                    if (rx_byte_reg == 8'hFE) begin
                        cnt_reg   <= '0;
                        state_reg <= S_DATA;
                    end else if (rx_byte_reg != 8'hFF) begin
                        err_reg   <= 2'd3;
                        state_reg <= S_TAIL;
                    end else if (cnt_reg == CW'(TOKEN_MAX - 1)) begin
                        err_reg   <= 2'd2;
                        state_reg <= S_TAIL;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                S_DATA: if (rx_valid_reg) begin
                    start_reg <= 1'b1;
                    if (cnt_reg == CW'(BLOCK_LEN - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= S_CRC;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                S_CRC: if (rx_valid_reg) begin
                    start_reg <= 1'b1;
                    if (cnt_reg == CW'(1)) state_reg <= S_TAIL;
                    else                   cnt_reg   <= cnt_reg + CW'(1);
                end
                S_TAIL: if (rx_valid_reg) begin
                    state_reg <= S_FIN;
                end
                // wait for the last byte's falling edge before releasing ss_n
                S_FIN: if (!eng_busy_reg) begin
                    ss_n_reg  <= 1'b1;
                    done_reg  <= 1'b1;
                    state_reg <= S_DONE;
                end
                S_DONE: begin
                    done_reg      <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                    state_reg     <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign r1         = r1_reg;
    assign resp       = resp_reg;
    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign spi_ss_n   = ss_n_reg;
    assign spi_sclk   = sclk_reg;
    assign spi_mosi   = mosi_reg;
endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// tb_sd_spi_cmd_engine
//   Drives sd_spi_cmd_engine against a byte-stream card model and compares
//   the outcome with a reference computed straight from the protocol rules.
module tb_sd_spi_cmd_engine;
    localparam int DIV_SLOW    = 125;
    localparam int DIV_FAST    = 2;
    localparam int NCR_MAX     = 16;
    localparam int TOKEN_MAX   = 8;
    localparam int BLOCK_LEN   = 512;
    localparam int DUMMY_BYTES = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0, dummy = 1'b0, fast = 1'b0, data_rd = 1'b0;
    logic [5:0]  cmd_idx = '0;
    logic [31:0] cmd_arg = '0;
    logic [2:0]  resp_len = '0;
    logic        spi_miso = 1'b1;
    logic        cmd_ready, done, dout_valid, spi_ss_n, spi_sclk, spi_mosi;
    logic [1:0]  err;
    logic [7:0]  r1, dout;
    logic [31:0] resp;

    sd_spi_cmd_engine #(
        .DIV_SLOW(DIV_SLOW), .DIV_FAST(DIV_FAST), .NCR_MAX(NCR_MAX),
        .TOKEN_MAX(TOKEN_MAX), .BLOCK_LEN(BLOCK_LEN), .DUMMY_BYTES(DUMMY_BYTES)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .dummy(dummy), .fast(fast), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
        .resp_len(resp_len), .data_rd(data_rd), .done(done), .err(err),
        .r1(r1), .resp(resp), .dout(dout), .dout_valid(dout_valid),
        .spi_ss_n(spi_ss_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // card side: bytes returned on miso, index = byte number in transaction
    logic [7:0] stream [0:2047];
    int         stream_len = 0;

    // monitor results
    int         rise_cnt = 0, ss_bad = 0, done_cnt = 0, ph_cnt = 0;
    int         hi_min, hi_max, lo_min, lo_max;
    logic       exp_ss = 1'b1;
    logic       prev_sclk = 1'b0;
    logic [7:0] mosi_bytes [0:2047];
    logic [7:0] dout_q [$];

    // reference results
    logic [1:0]  exp_err;
    logic [7:0]  exp_r1;
    logic [31:0] exp_resp;
    int          exp_bytes;
    logic [7:0]  exp_data [$];
    logic [7:0]  exp_frame [0:5];

    function automatic logic [7:0] sb(input int n);
        return (n < stream_len) ? stream[n] : 8'hFF;
    endfunction

    function automatic logic card_bit(input int n);
        logic [7:0] b;
        b = sb(n / 8);
        return b[7 - (n % 8)];
    endfunction

    // CRC7 by long division of msg*x^7 by x^7+x^3+1
    function automatic logic [7:0] crc_byte(input logic [39:0] msg);
        logic [46:0] v;
        v = {msg, 7'd0};
        for (int b = 46; b >= 7; b--)
            if (v[b]) v = v ^ (47'h89 << (b - 7));
        return {v[6:0], 1'b1};
    endfunction

    always @(negedge clk) begin
        if (spi_sclk !== prev_sclk) begin
            if (spi_sclk) begin
                if (rise_cnt > 0) begin
                    lo_min = (ph_cnt < lo_min) ? ph_cnt : lo_min;
                    lo_max = (ph_cnt > lo_max) ? ph_cnt : lo_max;
                end
                if (rise_cnt / 8 < 2048)
                    mosi_bytes[rise_cnt / 8] = {mosi_bytes[rise_cnt / 8][6:0], spi_mosi};
                if (spi_ss_n !== exp_ss) ss_bad++;
                rise_cnt++;
                spi_miso = card_bit(rise_cnt);
            end else begin
                hi_min = (ph_cnt < hi_min) ? ph_cnt : hi_min;
                hi_max = (ph_cnt > hi_max) ? ph_cnt : hi_max;
            end
            ph_cnt = 1;
        end else begin
            ph_cnt++;
        end
        prev_sclk = spi_sclk;
        if (done === 1'b1) done_cnt++;
        if (dout_valid === 1'b1) dout_q.push_back(dout);
    end

    // reference: walk the card byte stream following the protocol rules
    task automatic model(input logic dm, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [2:0] rl_in, input logic drd);
        int p, rl;
        bit found, tok;
        logic [7:0] b;
        exp_data.delete();
        exp_err = 2'd0; exp_r1 = 8'h00; exp_resp = 32'h0;
        exp_frame[0] = {2'b01, idx};
        for (int k = 0; k < 4; k++) exp_frame[k + 1] = 8'(arg >> (24 - 8 * k));
        exp_frame[5] = crc_byte({2'b01, idx, arg});
        if (dm) begin
            exp_bytes = DUMMY_BYTES;
            return;
        end
        p = 6; found = 0;
        for (int k = 0; k < NCR_MAX && !found; k++) begin
            b = sb(p); p++;
            if (b < 8'h80) begin found = 1; exp_r1 = b; end
        end
        if (!found) exp_err = 2'd1;
        else begin
            rl = (rl_in > 3'd4) ? 4 : int'(rl_in);
            for (int k = 0; k < rl; k++) begin exp_resp = (exp_resp << 8) | 32'(sb(p)); p++; end
            if (drd) begin
                tok = 0;
                for (int k = 0; k < TOKEN_MAX && !tok; k++) begin
                    b = sb(p); p++;
                    if (b == 8'hFE) begin
                        for (int d = 0; d < BLOCK_LEN; d++) begin exp_data.push_back(sb(p)); p++; end
                        p += 2;
                        tok = 1;
                    end else if (b != 8'hFF) begin
                        exp_err = 2'd3; tok = 1;
                    end
                end
                if (!tok) exp_err = 2'd2;
            end
        end
        exp_bytes = p + 1;
    endtask

    task automatic arm_monitor(input logic ss);
        rise_cnt = 0; ss_bad = 0; done_cnt = 0; ph_cnt = 0;
        hi_min = 1000000; hi_max = 0; lo_min = 1000000; lo_max = 0;
        dout_q.delete();
        exp_ss = ss;
        spi_miso = card_bit(0);
    endtask

    task automatic run_txn(input logic dm, input logic fs, input logic [5:0] idx,
                           input logic [31:0] arg, input logic [2:0] rl, input logic drd,
                           input logic poke);
        int div, limit, n;
        div = fs ? DIV_FAST : DIV_SLOW;
        model(dm, idx, arg, rl, drd);
        @(posedge clk); #1;
        arm_monitor(dm);
        cmd_valid = 1'b1; dummy = dm; fast = fs; cmd_idx = idx; cmd_arg = arg;
        resp_len = rl; data_rd = drd;
        check("ready_before", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; dummy = ~dm; fast = ~fs; cmd_idx = 6'($urandom);
        cmd_arg = $urandom; resp_len = 3'($urandom); data_rd = ~drd;
        check("ready_busy", 32'(cmd_ready), 32'd0);
        if (poke) begin
            repeat (30) @(posedge clk);
            #1 cmd_valid = 1'b1;
            @(posedge clk); #1 cmd_valid = 1'b0;
        end
        limit = exp_bytes * 16 * div + 400;
        n = 0;
        while (done_cnt == 0 && n < limit) begin @(posedge clk); n++; end
        check("done_seen", 32'(done_cnt != 0), 32'd1);
        repeat (40) @(posedge clk); #1;
        check("done_cnt", 32'(done_cnt), 32'd1);
        check("err", 32'(err), 32'(exp_err));
        if (!dm && exp_err != 2'd1) check("r1", 32'(r1), 32'(exp_r1));
        if (!dm) check("resp", resp, exp_resp);
        check("sclk_rises", 32'(rise_cnt), 32'(exp_bytes * 8));
        if (!dm)
            for (int k = 0; k < 6; k++) check($sformatf("frame%0d", k), 32'(mosi_bytes[k]), 32'(exp_frame[k]));
        n = 0;
        for (int k = (dm ? 0 : 6); k < exp_bytes; k++) if (mosi_bytes[k] != 8'hFF) n++;
        check("mosi_idle_ff", 32'(n), 32'd0);
        check("ss_level", 32'(ss_bad), 32'd0);
        check("pins_idle", {29'd0, spi_ss_n, spi_sclk, spi_mosi}, 32'b101);
        check("ready_after", 32'(cmd_ready), 32'd1);
        check("hi_min", 32'(hi_min), 32'(div));
        check("hi_max", 32'(hi_max), 32'(div));
        if (exp_bytes > 1 || !dm) begin
            check("lo_min", 32'(lo_min), 32'(div));
            check("lo_max", 32'(lo_max), 32'(div));
        end
        check("dout_count", 32'(dout_q.size()), 32'(exp_data.size()));
        n = 0;
        for (int k = 0; k < exp_data.size() && k < dout_q.size(); k++)
            if (dout_q[k] != exp_data[k]) n++;
        check("dout_bytes_bad", 32'(n), 32'd0);
        $display("txn dm=%0b fast=%0b idx=%0d arg=%08h rl=%0d rd=%0b -> err=%0d r1=%02h resp=%08h bytes=%0d dout=%0d",
                 dm, fs, idx, arg, rl, drd, err, r1, resp, rise_cnt / 8, dout_q.size());
    endtask

    task automatic fill_read(input logic [7:0] token);
        int p;
        for (int k = 0; k < 6; k++) stream[k] = 8'hFF;
        stream[6] = 8'h00;
        stream[7] = 8'hFF; stream[8] = 8'hFF; stream[9] = 8'hFF;
        stream[10] = token;
        p = 11;
        for (int k = 0; k < BLOCK_LEN; k++) begin stream[p] = 8'(k % 256); p++; end
        stream[p] = 8'h3C; stream[p + 1] = 8'hA5;
        stream_len = p + 2;
    endtask

    task automatic fill_random(input logic [2:0] rl, input logic drd);
        int p, w, t, nrl;
        p = 6;
        for (int k = 0; k < 6; k++) stream[k] = 8'hFF;
        w = $urandom_range(0, NCR_MAX);
        for (int k = 0; k < w; k++) begin stream[p] = 8'hFF; p++; end
        if (w < NCR_MAX) begin
            stream[p] = 8'($urandom_range(0, 127)); p++;
            nrl = (rl > 3'd4) ? 4 : int'(rl);
            for (int k = 0; k < nrl; k++) begin stream[p] = 8'($urandom); p++; end
            if (drd) begin
                t = $urandom_range(0, TOKEN_MAX);
                for (int k = 0; k < t; k++) begin stream[p] = 8'hFF; p++; end
                if (t < TOKEN_MAX) begin
                    stream[p] = 8'($urandom_range(0, 253));
                    p++;
                end
            end
        end
        stream_len = p;
    endtask

    initial begin
        int n;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pins", {29'd0, spi_ss_n, spi_sclk, spi_mosi}, 32'b101);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_done_dv", {30'd0, done, dout_valid}, 32'd0);
        check("rst_err_r1", {22'd0, err, r1}, 32'd0);
        check("rst_resp", resp, 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // CMD0 at init speed
        for (int k = 0; k < 6; k++) stream[k] = 8'hFF;
        stream[6] = 8'hFF; stream[7] = 8'hFF; stream[8] = 8'h01;
        stream_len = 9;
        run_txn(1'b0, 1'b0, 6'd0, 32'h0, 3'd0, 1'b0, 1'b0);
        check("cmd0_crc", 32'(mosi_bytes[5]), 32'h95);

        // CMD8 with R7
        for (int k = 0; k < 6; k++) stream[k] = 8'hFF;
        stream[6] = 8'h01; stream[7] = 8'h00; stream[8] = 8'h00; stream[9] = 8'h01; stream[10] = 8'hAA;
        stream_len = 11;
        run_txn(1'b0, 1'b1, 6'd8, 32'h000001AA, 3'd4, 1'b0, 1'b1);
        check("cmd8_crc", 32'(mosi_bytes[5]), 32'h87);

        // no response at all
        stream_len = 0;
        run_txn(1'b0, 1'b1, 6'd55, 32'h12345678, 3'd2, 1'b1, 1'b0);

        // block read, then same read with an error token
        fill_read(8'hFE);
        run_txn(1'b0, 1'b1, 6'd17, 32'h00000200, 3'd0, 1'b1, 1'b0);
        fill_read(8'h05);
        run_txn(1'b0, 1'b1, 6'd17, 32'h00000200, 3'd0, 1'b1, 1'b0);

        // power-up dummy clocks
        stream_len = 0;
        run_txn(1'b1, 1'b1, 6'd3, 32'hDEADBEEF, 3'd1, 1'b1, 1'b1);

        // randomized commands
        for (int i = 0; i < 16; i++) begin
            logic dm, drd;
            logic [2:0] rl;
            dm  = ($urandom_range(0, 7) == 0);
            drd = $urandom_range(0, 1) != 0;
            rl  = 3'($urandom_range(0, 7));
            fill_random(rl, drd);
            run_txn(dm, 1'b1, 6'($urandom), $urandom, rl, drd, $urandom_range(0, 1) != 0);
        end

        // reset in the middle of a data block
        fill_read(8'hFE);
        @(posedge clk); #1;
        arm_monitor(1'b0);
        cmd_valid = 1'b1; dummy = 1'b0; fast = 1'b1; cmd_idx = 6'd17; cmd_arg = 32'h0;
        resp_len = 3'd0; data_rd = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        n = 0;
        while (dout_q.size() < 20 && n < 20000) begin @(posedge clk); n++; end
        check("mid_data_reached", 32'(dout_q.size() >= 20), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        check("rst_mid_pins", {30'd0, spi_ss_n, spi_sclk}, 32'b10);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        check("rst_mid_no_done", 32'(done_cnt), 32'd0);
        check("rst_mid_pins_after", {29'd0, spi_ss_n, spi_sclk, spi_mosi}, 32'b101);
        $display("reset mid-data after %0d data bytes", dout_q.size());

        // engine still works after the abort
        for (int k = 0; k < 6; k++) stream[k] = 8'hFF;
        stream[6] = 8'h01; stream[7] = 8'h00; stream[8] = 8'h00; stream[9] = 8'h01; stream[10] = 8'hAA;
        stream_len = 11;
        run_txn(1'b0, 1'b1, 6'd8, 32'h000001AA, 3'd4, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
